// File: rtl/cellrv32_clkgen.sv
// cellrv32_clkgen: shared prescaler tick generator; a 12-bit divider runs only while any peripheral requests it.
module cellrv32_clkgen #(
   parameter int NUM_REQ = 8
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [NUM_REQ-1:0] en_i,
   input  logic               clr_i,
   output logic [7:0]         clkgen_o,
   output logic               active_o
);
   logic        en_q, en_d;
   logic [11:0] cnt_q, cnt_d, cnt_prev_q, cnt_prev_d;
   logic [7:0]  clkgen_q, clkgen_d;
   logic [7:0]  src_cur, src_prev;
   logic        en_any;
   assign src_cur  = {cnt_q[11], cnt_q[10], cnt_q[9], cnt_q[6], cnt_q[5], cnt_q[2], cnt_q[1], cnt_q[0]};
   assign src_prev = {cnt_prev_q[11], cnt_prev_q[10], cnt_prev_q[9], cnt_prev_q[6],
                      cnt_prev_q[5], cnt_prev_q[2], cnt_prev_q[1], cnt_prev_q[0]};
   always_comb begin
      en_any     = |en_i;
      en_d       = en_any;
      cnt_d      = (!en_q || clr_i) ? 12'd0 : cnt_q + 12'd1;
      cnt_prev_d = (!en_q || clr_i) ? 12'd0 : cnt_q;
      // gating with the live request keeps the outputs silent in the very cycle en_q drops
      clkgen_d   = (en_q && en_any) ? (src_cur & ~src_prev) : 8'h00;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         en_q       <= 1'b0;
         cnt_q      <= 12'd0;
         cnt_prev_q <= 12'd0;
         clkgen_q   <= 8'h00;
      end else begin
         en_q       <= en_d;
         cnt_q      <= cnt_d;
         cnt_prev_q <= cnt_prev_d;
         clkgen_q   <= clkgen_d;
      end
   end
   assign clkgen_o = clkgen_q;
   assign active_o = en_q;
endmodule

// File: tb/tb_cellrv32_clkgen.sv
// tb_cellrv32_clkgen: scoreboard bench; the driver pushes the expected tick/active vector for each edge.
module tb_cellrv32_clkgen;
   logic       clk_i = 1'b0;
   logic       rstn_i = 1'b0;
   logic [7:0] en_i = 8'h00;
   logic       clr_i = 1'b0;
   logic [7:0] clkgen_o;
   logic       active_o;
   always #5 clk_i = ~clk_i;
   cellrv32_clkgen #(.NUM_REQ(8)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .clr_i(clr_i),
      .clkgen_o(clkgen_o), .active_o(active_o)
   );
   typedef struct packed {logic [7:0] clk; logic act;} exp_t;
   exp_t exp_q[$];
   int tests = 0, fails = 0;
   int pulses[8];
   int snap[8];
   int dv[8]       = '{2, 4, 8, 64, 128, 1024, 2048, 4096};
   int exp_cnt[8]  = '{4999, 2500, 1250, 156, 78, 10, 5, 2};
   bit m_en = 1'b0;
   int n = 0;
   // edge n counted from the enabling edge E0: select k pulses after E(D/2+1), then every D edges
   function automatic logic [7:0] tick(input int nn);
      logic [7:0] t;
      for (int k = 0; k < 8; k++) t[k] = (nn >= 2) && (((nn - 1) % dv[k]) == dv[k] / 2);
      return t;
   endfunction
   task automatic step(input logic [7:0] en, input logic clr, input logic rn);
      exp_t e;
      @(negedge clk_i);
      en_i = en;
      clr_i = clr;
      if (rstn_i && !rn) begin
         rstn_i = 1'b0;
         #1;
         tests++;
         if (clkgen_o !== 8'h00 || active_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got clkgen=%h active=%b want 00/0", clkgen_o, active_o);
         end
      end
      rstn_i = rn;
      e = '{clk: 8'h00, act: 1'b0};
      if (!rn) begin
         m_en = 1'b0;
         n = 0;
      end else begin
         if (m_en && |en) begin
            e.clk = tick(n + 1);
            n = clr ? 0 : n + 1;
         end else n = 0;
         m_en = |en;
         e.act = |en;
      end
      exp_q.push_back(e);
   endtask
   task automatic run(input int cyc, input logic [7:0] en);
      for (int i = 0; i < cyc; i++) step(en, 1'b0, 1'b1);
   endtask
   initial begin
      for (int k = 0; k < 8; k++) pulses[k] = 0;
      forever begin
         exp_t e;
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (clkgen_o !== e.clk || active_o !== e.act) begin
               fails++;
               $display("FAIL tick t=%0t got clkgen=%h active=%b want clkgen=%h active=%b",
                        $time, clkgen_o, active_o, e.clk, e.act);
            end
            for (int k = 0; k < 8; k++) pulses[k] += int'(clkgen_o[k]);
         end
      end
   end
   initial begin
      int w;
      for (int i = 0; i < 5; i++) step(8'hff, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) snap[k] = pulses[k];
      run(10000, 8'h01);
      run(2, 8'h00);
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (pulses[k] - snap[k] != exp_cnt[k]) begin
            fails++;
            $display("FAIL pulse_count sel%0d got %0d want %0d", k, pulses[k] - snap[k], exp_cnt[k]);
         end
      end
      run(37, 8'h01);
      run(5, 8'h00);
      run(40, 8'h01);
      run(3, 8'h00);
      run(100, 8'h01);
      run(100, 8'h09);
      run(50, 8'h08);
      run(5, 8'h00);
      run(50, 8'h01);
      step(8'h01, 1'b1, 1'b1);
      run(20, 8'h01);
      run(3, 8'h00);
      step(8'h01, 1'b1, 1'b1);
      run(12, 8'h01);
      step(8'h01, 1'b0, 1'b0);
      step(8'h01, 1'b0, 1'b0);
      run(12, 8'h01);
      w = 0;
      while (exp_q.size() > 0 && w < 10) begin
         @(posedge clk_i);
         w++;
      end
      #2;
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
